// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller between the MEM stage and a word-wide
// data memory (asynchronous read, synchronous write).
//
// Byte/half/word requests arrive on a valid/ready handshake. Sub-word stores
// become read-modify-write sequences. Loads are aligned, then sign- or
// zero-extended. Every request, including a rejected one, ends with a
// one-cycle rsp_valid pulse.
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   : requests crossing a word boundary are split into two word
//               accesses (states RD1/WR1 present).
//   undefined : crossing requests are rejected with rsp_err at T+1.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   req_valid     request present
//   req_ready     controller can accept (IDLE only)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  load zero-extends when 1
//   req_addr      byte address, little-endian
//   req_wdata     store data, LSB-justified
//   rsp_valid     one-cycle completion pulse, no back-pressure
//   rsp_rdata     load result (0 for stores and errors), held until next RESP
//   rsp_err       request rejected, held until next RESP
//   mem_we        memory write enable
//   mem_addr      memory address {word_index, 2'b00}
//   mem_wdata     memory write data
//   mem_rdata     memory read data, combinational from mem_addr
//
// Handshake: a request transfers in the cycle where req_valid && req_ready
// are both high; all req_* fields are sampled on that clock edge and need not
// be held afterwards. rsp_valid is a single-cycle pulse that is not stalled.
module lsu_mem_ctrl #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int SPAN = 64;
`else
  localparam int SPAN = 32;
`endif
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_WR0  = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
    S_RD1  = 3'd3,
    S_WR1  = 3'd4,
`endif
    S_RESP = 3'd5
  } state_t;

  state_t state, state_d;

  logic        ready_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [29:0] w0_q;
  logic [31:0] wdata_q;
  logic [31:0] buf0_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic        cross_q;
  logic [31:0] buf1_q;
  logic [29:0] w1;
`endif

  // Accept-time decode
  logic        accept;
  logic [2:0]  n_in;
  logic        cross_in;
  logic        oor0;
  logic        err_in;
  logic        full_word_in;

  assign accept       = req_valid && req_ready;
  assign oor0         = {2'b00, req_addr[31:2]} >= MEM_LIMIT;
  assign cross_in     = ({1'b0, req_addr[1:0]} + n_in) > 3'd4;
  assign full_word_in = (req_size == 2'b10) && (req_addr[1:0] == 2'b00);

  always_comb begin
    n_in = 3'd0;
    case (req_size)
      2'b00:   n_in = 3'd1;
      2'b01:   n_in = 3'd2;
      2'b10:   n_in = 3'd4;
      default: n_in = 3'd0;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign err_in = (req_size == 2'b11) || oor0 ||
                  (cross_in && (({2'b00, req_addr[31:2]} + 32'd1) >= MEM_LIMIT));
  assign w1     = w0_q + 30'd1;
`else
  assign err_in = (req_size == 2'b11) || oor0 || cross_in;
`endif

  // Byte lane merge/extract over the word pair {word1, word0}
  logic [31:0]     bmask;
  logic [4:0]      sh;
  logic [31:0]     cur0;
  logic [SPAN-1:0] old_span;
  logic [SPAN-1:0] mask_span;
  logic [SPAN-1:0] data_span;
  logic [SPAN-1:0] merged;
  logic [SPAN-1:0] load_span;
  logic [31:0]     load_raw;
  logic [31:0]     load_val;

  always_comb begin
    bmask = 32'h0;
    case (size_q)
      2'b00:   bmask = 32'h0000_00FF;
      2'b01:   bmask = 32'h0000_FFFF;
      2'b10:   bmask = 32'hFFFF_FFFF;
      default: bmask = 32'h0;
    endcase
  end

  assign sh = {off_q, 3'b000};

  // The word being read this cycle is not in a buffer yet, so the load
  // result is formed from mem_rdata directly on the edge entering RESP.
  assign cur0 = (state == S_RD0) ? mem_rdata : buf0_q;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0] cur1;
  assign cur1      = (state == S_RD1) ? mem_rdata : buf1_q;
  assign old_span  = {buf1_q, buf0_q};
  assign load_span = {cur1, cur0};
`else
  assign old_span  = buf0_q;
  assign load_span = cur0;
`endif

  // For an aligned word store buf0_q is never read; the mask covers all of
  // word 0, so its stale contents do not reach mem_wdata.
  assign mask_span = SPAN'(bmask) << sh;
  assign data_span = SPAN'(wdata_q) << sh;
  assign merged    = (old_span & ~mask_span) | (data_span & mask_span);
  assign load_raw  = 32'(load_span >> sh);

  always_comb begin
    load_val = load_raw;
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & load_raw[7]}}, load_raw[7:0]};
      2'b01:   load_val = {{16{~uns_q & load_raw[15]}}, load_raw[15:0]};
      default: load_val = load_raw;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (err_in)                      state_d = S_RESP;
          else if (req_we && full_word_in) state_d = S_WR0;
          else                             state_d = S_RD0;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_RD0:  state_d = we_q ? S_WR0 : (cross_q ? S_RD1 : S_RESP);
      S_WR0:  state_d = cross_q ? S_RD1 : S_RESP;
      S_RD1:  state_d = we_q ? S_WR1 : S_RESP;
      S_WR1:  state_d = S_RESP;
`else
      S_RD0:  state_d = we_q ? S_WR0 : S_RESP;
      S_WR0:  state_d = S_RESP;
`endif
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      w0_q        <= 30'd0;
      wdata_q     <= 32'h0;
      buf0_q      <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q     <= 1'b0;
      buf1_q      <= 32'h0;
`endif
    end else begin
      state   <= state_d;
      // Holds req_ready low through the first cycle after reset release.
      ready_q <= 1'b1;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
        w0_q    <= req_addr[31:2];
        wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        cross_q <= cross_in;
`endif
      end
      if (state == S_RD0) buf0_q <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state == S_RD1) buf1_q <= mem_rdata;
`endif
      // Entering RESP straight from IDLE only happens for a rejected request.
      if (state_d == S_RESP && state != S_RESP) begin
        rsp_err_q   <= (state == S_IDLE);
        rsp_rdata_q <= ((state == S_IDLE) || we_q) ? 32'h0 : load_val;
      end
    end
  end

  // Outputs
  assign req_ready = ready_q && (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      S_RD0: mem_addr = {w0_q, 2'b00};
      S_WR0: begin
        mem_we    = 1'b1;
        mem_addr  = {w0_q, 2'b00};
        mem_wdata = merged[31:0];
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_RD1: mem_addr = {w1, 2'b00};
      S_WR1: begin
        mem_we    = 1'b1;
        mem_addr  = {w1, 2'b00};
        mem_wdata = merged[63:32];
      end
`endif
      default: ;
    endcase
  end

endmodule
